// File: rtl/sgd_x_updated_ctrl.sv
// x_updated BRAM access controller: arbitrates the update pipeline, a clear sweep
// and a flow-controlled model readback stream onto a single BRAM port pair.
module sgd_x_updated_ctrl #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned RD_LAT    = 3,
    parameter int unsigned IDX_SHIFT = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       dimension,
    input  logic              started,
    input  logic              cmd_clear,
    input  logic              cmd_dump,
    output logic              busy,
    output logic              done,
    input  logic [ADDR_W-1:0] upd_rd_addr,
    input  logic              upd_wr_en,
    input  logic [ADDR_W-1:0] upd_wr_addr,
    input  logic [DATA_W-1:0] upd_wr_data,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic              dump_last
);

    localparam int unsigned NW         = ADDR_W + 1;
    localparam logic [31:0] LOW_MASK   = (32'd1 << IDX_SHIFT) - 32'd1;
    localparam logic [2:0]  DRAIN_LAST = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRAIN,
        S_CLEAR,
        S_DRAIN,
        S_DUMP
    } state_t;

    state_t            state_q, state_d;
    logic [NW-1:0]     n_q, n_d;
    logic [NW-1:0]     cmd_n_q, cmd_n_d;
    logic [NW-1:0]     addr_q, addr_d;
    logic [NW-1:0]     pop_cnt_q, pop_cnt_d;
    logic [2:0]        drain_q, drain_d;
    logic [RD_LAT-1:0] pipe_q, pipe_d;
    logic [2:0]        out_q, out_d;
    logic [2:0]        fifo_cnt_q, fifo_cnt_d;
    logic [1:0]        wp_q, rp_q;
    logic [DATA_W-1:0] fifo_mem [4];

    logic issue, capture, pop;

    // Word count rounds up any partial bank/engine group.
    assign n_d = NW'(dimension >> IDX_SHIFT) + NW'(|(dimension & LOW_MASK));

    assign issue   = (state_q == S_DUMP) && (addr_q < cmd_n_q) &&
                     (({1'b0, out_q} + {1'b0, fifo_cnt_q}) < 4'd4);
    assign capture = pipe_q[RD_LAT-1];
    assign dump_valid = (fifo_cnt_q != 3'd0);
    assign pop        = dump_valid && dump_ready;
    assign dump_data  = dump_valid ? fifo_mem[rp_q] : '0;
    assign dump_last  = dump_valid && ((pop_cnt_q + NW'(1)) == cmd_n_q);

    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = issue;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_comb begin
        out_d = out_q;
        case ({issue, capture})
            2'b10:   out_d = out_q + 3'd1;
            2'b01:   out_d = out_q - 3'd1;
            default: out_d = out_q;
        endcase
        fifo_cnt_d = fifo_cnt_q;
        case ({capture, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cmd_n_d     = cmd_n_q;
        addr_d      = addr_q;
        pop_cnt_d   = pop ? pop_cnt_q + NW'(1) : pop_cnt_q;
        drain_d     = drain_q;
        busy        = 1'b0;
        done        = 1'b0;
        mem_rd_addr = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        case (state_q)
            S_IDLE: begin
                if (started) begin
                    state_d = S_TRAIN;
                end else if (cmd_clear) begin
                    state_d = S_CLEAR;
                    cmd_n_d = n_q;
                    addr_d  = '0;
                end else if (cmd_dump) begin
                    state_d   = S_DUMP;
                    cmd_n_d   = n_q;
                    addr_d    = '0;
                    pop_cnt_d = '0;
                end
            end
            S_TRAIN: begin
                mem_rd_addr = upd_rd_addr;
                mem_wr_en   = upd_wr_en;
                mem_wr_addr = upd_wr_addr;
                mem_wr_data = upd_wr_data;
                if (!started) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end
            end
            S_DRAIN: begin
                // Writes still in the update pipeline must land after training stops.
                busy        = 1'b1;
                mem_wr_en   = upd_wr_en;
                mem_wr_addr = upd_wr_addr;
                mem_wr_data = upd_wr_data;
                if (started) begin
                    state_d = S_TRAIN;
                end else if (drain_q == DRAIN_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            S_CLEAR: begin
                busy = 1'b1;
                if (addr_q < cmd_n_q) begin
                    mem_wr_en   = 1'b1;
                    mem_wr_addr = addr_q[ADDR_W-1:0];
                    addr_d      = addr_q + NW'(1);
                end else begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DUMP: begin
                busy        = 1'b1;
                mem_rd_addr = addr_q[ADDR_W-1:0];
                if (issue) begin
                    addr_d = addr_q + NW'(1);
                end
                if (pop_cnt_q == cmd_n_q) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            cmd_n_q    <= '0;
            addr_q     <= '0;
            pop_cnt_q  <= '0;
            drain_q    <= '0;
            pipe_q     <= '0;
            out_q      <= '0;
            fifo_cnt_q <= '0;
            wp_q       <= '0;
            rp_q       <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            cmd_n_q    <= cmd_n_d;
            addr_q     <= addr_d;
            pop_cnt_q  <= pop_cnt_d;
            drain_q    <= drain_d;
            pipe_q     <= pipe_d;
            out_q      <= out_d;
            fifo_cnt_q <= fifo_cnt_d;
            if (capture) wp_q <= wp_q + 2'd1;
            if (pop)     rp_q <= rp_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) fifo_mem[wp_q] <= mem_rd_data;
    end

endmodule

// File: tb/tb_sgd_x_updated_ctrl.sv
// Directed bench for sgd_x_updated_ctrl with a 3-cycle-latency BRAM model.
module tb_sgd_x_updated_ctrl;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       dimension;
    logic              started, cmd_clear, cmd_dump;
    logic              busy, done;
    logic [ADDR_W-1:0] upd_rd_addr, upd_wr_addr;
    logic              upd_wr_en;
    logic [DATA_W-1:0] upd_wr_data;
    logic [ADDR_W-1:0] mem_rd_addr, mem_wr_addr;
    logic [DATA_W-1:0] mem_rd_data, mem_wr_data;
    logic              mem_wr_en;
    logic [DATA_W-1:0] dump_data;
    logic              dump_valid, dump_ready, dump_last;

    int checks = 0;
    int passes = 0;

    sgd_x_updated_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(3), .IDX_SHIFT(9)
    ) dut (
        .clk(clk), .rst(rst), .dimension(dimension), .started(started),
        .cmd_clear(cmd_clear), .cmd_dump(cmd_dump), .busy(busy), .done(done),
        .upd_rd_addr(upd_rd_addr), .upd_wr_en(upd_wr_en), .upd_wr_addr(upd_wr_addr),
        .upd_wr_data(upd_wr_data), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .dump_data(dump_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_last(dump_last)
    );

    always #5 clk = ~clk;

    // BRAM model: registered read, two extra output stages (3 cycles addr->data).
    logic [DATA_W-1:0] bram [256];
    logic [DATA_W-1:0] rp0, rp1, rp2;
    logic              pre_en = 1'b0;
    logic [ADDR_W-1:0] pre_addr;
    logic [DATA_W-1:0] pre_data;

    always @(posedge clk) begin
        if (pre_en) bram[pre_addr] <= pre_data;
        else if (mem_wr_en) bram[mem_wr_addr] <= mem_wr_data;
        rp0 <= bram[mem_rd_addr];
        rp1 <= rp0;
        rp2 <= rp1;
    end
    assign mem_rd_data = rp2;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic preload(input int count);
        for (int k = 0; k < count; k++) begin
            pre_en = 1'b1; pre_addr = ADDR_W'(k); pre_data = DATA_W'(k);
            tick;
        end
        pre_en = 1'b0;
    endtask

    function automatic logic rdy(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (c >= 4 && c < 14) return 1'b0;
        return (c % 2) == 0;
    endfunction

    // Runs a full N=5 dump against bram[k]=k and checks order, last, stall hold and done.
    task automatic run_dump(input int mode);
        int idx = 0;
        int dones = 0;
        int c = 0;
        logic stall_prev = 1'b0;
        logic [DATA_W-1:0] prev_data = '0;
        cmd_dump = 1'b1;
        tick;
        cmd_dump = 1'b0;
        while (c < 80 && dones == 0) begin
            dump_ready = rdy(mode, c);
            #1;
            if (stall_prev) chk("stall_hold", {dump_valid, dump_data}, {1'b1, prev_data});
            chk("outstanding_le4", (int'(mem_rd_addr) - idx) <= 4, 1);
            if (done) begin
                dones++;
                chk("done_after_last", idx, 5);
            end
            if (dump_valid && dump_ready) begin
                chk("dump_data", dump_data, idx);
                chk("dump_last", dump_last, idx == 4);
                idx++;
            end
            stall_prev = dump_valid && !dump_ready;
            prev_data  = dump_data;
            tick;
            c++;
        end
        chk("dump_words", idx, 5);
        chk("dump_done_count", dones, 1);
        chk("dump_done_low", done, 0);
        chk("dump_busy_low", busy, 0);
        dump_ready = 1'b0;
    endtask

    initial begin
        int idx;
        rst = 1'b1; dimension = '0; started = 1'b0; cmd_clear = 1'b0; cmd_dump = 1'b0;
        upd_rd_addr = '0; upd_wr_en = 1'b0; upd_wr_addr = '0; upd_wr_data = '0;
        dump_ready = 1'b0; pre_addr = '0; pre_data = '0;
        tick; tick;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_wr_en", mem_wr_en, 0);
        chk("rst_dump_valid", dump_valid, 0);
        chk("rst_dump_last", dump_last, 0);
        chk("rst_mem_rd_addr", mem_rd_addr, 0);
        chk("rst_mem_wr_addr", mem_wr_addr, 0);
        chk("rst_dump_data", dump_data, 0);
        rst = 1'b0;
        preload(7);

        // Clear with N=2.
        dimension = 32'd1024;
        tick;
        cmd_clear = 1'b1;
        tick;
        cmd_clear = 1'b0;
        chk("clr0_wr", {mem_wr_en, mem_wr_addr, mem_wr_data}, {1'b1, 8'd0, 32'd0});
        chk("clr0_busy_done", {busy, done}, 2'b10);
        tick;
        chk("clr1_wr", {mem_wr_en, mem_wr_addr, mem_wr_data}, {1'b1, 8'd1, 32'd0});
        tick;
        chk("clr_end", {mem_wr_en, done, busy}, 3'b011);
        tick;
        chk("clr_idle", {done, busy}, 2'b00);
        chk("clr_bram0", bram[0], 0);
        chk("clr_bram1", bram[1], 0);

        // Dump N=5 (dimension 2049 rounds up), free-flowing then stalled.
        preload(5);
        dimension = 32'd2049;
        tick;
        run_dump(0);
        run_dump(1);

        // Training passthrough and drain window.
        started = 1'b1;
        tick;
        chk("train_busy", busy, 0);
        upd_wr_en = 1'b1; upd_wr_addr = 8'd3; upd_wr_data = 32'hA5A5; upd_rd_addr = 8'd7;
        #1;
        chk("train_pass", {mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr},
            {1'b1, 8'd3, 32'hA5A5, 8'd7});
        tick;
        upd_wr_en = 1'b0;
        chk("train_bram3", bram[3], 32'hA5A5);
        started = 1'b0;
        repeat (5) tick;
        chk("drain_busy", busy, 1);
        upd_wr_en = 1'b1; upd_wr_addr = 8'd5; upd_wr_data = 32'h5555;
        #1;
        chk("drain_pass", mem_wr_en, 1);
        tick;
        upd_wr_en = 1'b0;
        chk("drain_last_busy", busy, 1);
        tick;
        chk("drain_exit", busy, 0);
        upd_wr_en = 1'b1; upd_wr_addr = 8'd6; upd_wr_data = 32'h6666;
        #1;
        chk("idle_wr_blocked", mem_wr_en, 0);
        tick;
        upd_wr_en = 1'b0;
        chk("drain_bram5", bram[5], 32'h5555);
        chk("idle_bram6", bram[6], 6);

        // Restart during drain keeps passthrough.
        started = 1'b1;
        tick;
        started = 1'b0;
        tick;
        chk("redrain_busy", busy, 1);
        started = 1'b1; upd_wr_en = 1'b1; upd_wr_addr = 8'd9; upd_wr_data = 32'h9;
        #1;
        chk("redrain_pass", mem_wr_en, 1);
        tick;
        upd_wr_en = 1'b0;
        chk("retrain_busy", busy, 0);
        started = 1'b0;
        repeat (8) tick;
        chk("retrain_idle", busy, 0);

        // Simultaneous commands and dump during clear.
        dimension = 32'd1024;
        tick;
        cmd_clear = 1'b1; cmd_dump = 1'b1;
        tick;
        cmd_clear = 1'b0;
        chk("both_clear_wins", {mem_wr_en, mem_wr_addr}, {1'b1, 8'd0});
        tick;
        cmd_dump = 1'b0;
        chk("clr_ignore_dump", {mem_wr_en, mem_wr_addr}, {1'b1, 8'd1});
        tick;
        chk("both_done", done, 1);
        repeat (6) tick;
        chk("no_queued_dump", {busy, dump_valid}, 2'b00);

        // Reset in the middle of a dump.
        preload(5);
        dimension = 32'd2049;
        tick;
        dump_ready = 1'b1;
        cmd_dump = 1'b1;
        tick;
        cmd_dump = 1'b0;
        idx = 0;
        for (int c = 0; c < 40 && idx < 2; c++) begin
            if (dump_valid) idx++;
            tick;
        end
        chk("pre_reset_words", idx, 2);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mid_rst_out", {dump_valid, done, busy}, 3'b000);
        for (int c = 0; c < 6; c++) begin
            chk("post_rst_quiet", {dump_valid, done}, 2'b00);
            tick;
        end
        dump_ready = 1'b0;
        run_dump(0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
